// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data load/store.
// Data wins by default; a starvation counter forces a fetch grant, and an owner-tag FIFO routes read data back.
module unified_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              resp_err
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [0:0] DATA_PRI  = 1'b0;
    localparam logic [0:0] FETCH_PRI = 1'b1;

    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [STV_W-1:0]           starve_cnt_q, starve_cnt_d;
    logic [0:0]                 arb_state_q, arb_state_d;
    logic                       resp_err_q, resp_err_d;

    logic fifo_full, i_elig, d_elig, sel_i, sel_d, grant_i, grant_d;
    logic push, pop, head_tag, starve_inc;

    // Loads and fetches are both reads, so a full tag FIFO blocks both; stores bypass it.
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign i_elig     = i_req_valid & ~fifo_full & ~reset;
    assign d_elig     = d_req_valid & (d_req_we | ~fifo_full) & ~reset;
    assign sel_i      = i_elig & ((arb_state_q == FETCH_PRI) | ~d_elig);
    assign sel_d      = d_elig & ~sel_i;
    assign grant_i    = sel_i & mem_req_ready;
    assign grant_d    = sel_d & mem_req_ready;
    assign push       = grant_i | (grant_d & ~d_req_we);
    assign pop        = mem_resp_valid & ~reset & (count_q != '0);
    assign head_tag   = tag_q[rd_ptr_q];
    assign starve_inc = i_elig & grant_d;

    assign i_req_ready   = grant_i;
    assign d_req_ready   = grant_d;
    assign mem_req_valid = (i_elig | d_elig) & mem_req_ready;
    assign mem_req_we    = sel_d & d_req_we;
    assign mem_req_addr  = sel_i ? i_req_addr : (sel_d ? d_req_addr : '0);
    assign mem_req_wdata = sel_d ? d_req_wdata : '0;

    assign i_resp_valid  = pop & ~head_tag;
    assign i_resp_data   = (pop & ~head_tag) ? mem_resp_data : '0;
    assign d_resp_valid  = pop & head_tag;
    assign d_resp_data   = (pop & head_tag) ? mem_resp_data : '0;
    assign resp_err      = resp_err_q & ~reset;

    always_comb begin
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;
        arb_state_d  = arb_state_q;
        resp_err_d   = resp_err_q | (mem_resp_valid & (count_q == '0));

        if (push) begin
            tag_d[wr_ptr_q] = grant_d;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (grant_i) begin
            starve_cnt_d = '0;
        end else if (starve_inc && starve_cnt_q != STV_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end

        // Tracks starve_cnt == STARVE_LIMIT exactly.
        case (arb_state_q)
            DATA_PRI: begin
                if (starve_inc && (starve_cnt_q + STV_W'(1) == STV_W'(STARVE_LIMIT)))
                    arb_state_d = FETCH_PRI;
            end
            default: begin
                if (grant_i)
                    arb_state_d = DATA_PRI;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            arb_state_q  <= DATA_PRI;
            resp_err_q   <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            arb_state_q  <= arb_state_d;
            resp_err_q   <= resp_err_d;
        end
    end
endmodule
